// File: rtl/register_bank.sv
// register_bank: register file with one write port and two independent
// registered read ports. Reads are write-first: a read of the entry being
// written at the same edge returns the incoming data. Optionally entry 0
// is hardwired to zero. wr_onehot gives a one-cycle pulse marking the
// entry written at the previous edge.
module register_bank #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_a,
    output logic             rd_valid_b,
    output logic [DEPTH-1:0] wr_onehot
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_eff;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    // A write only takes effect when it does not target a hardwired-zero entry 0.
    always_comb begin
        wr_eff = wr_en;
        if (ZERO_REG != 0 && wr_addr == '0) begin
            wr_eff = 1'b0;
        end
    end

    // Port A read value: stored contents, overridden by same-edge write data, forced to zero for entry 0 if hardwired.
    always_comb begin
        rd_next_a = mem[rd_addr_a];
        if (wr_eff && wr_addr == rd_addr_a) begin
            rd_next_a = wr_data;
        end
        if (ZERO_REG != 0 && rd_addr_a == '0) begin
            rd_next_a = '0;
        end
    end

    // Port B read value, built the same way as port A.
    always_comb begin
        rd_next_b = mem[rd_addr_b];
        if (wr_eff && wr_addr == rd_addr_b) begin
            rd_next_b = wr_data;
        end
        if (ZERO_REG != 0 && rd_addr_b == '0) begin
            rd_next_b = '0;
        end
    end

    // Storage array: cleared by reset, otherwise updated by effective writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_eff) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered outputs: read data held when not requested, valid and one-hot pulse for a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            wr_onehot  <= '0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= rd_next_a;
            end
            if (rd_en_b) begin
                rd_data_b <= rd_next_b;
            end
            wr_onehot <= wr_eff ? (DEPTH'(1) << wr_addr) : '0;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed and randomized checks of register_bank against
// an array-based reference model. Two 8x8 instances (plain and with entry 0
// hardwired to zero) share one stimulus; a 16x32 instance gets a long
// random stream.
module tb_register_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8x8 stimulus shared by both small instances
    logic       rst8 = 1'b1, we8 = 1'b0, rea8 = 1'b0, reb8 = 1'b0;
    logic [2:0] wa8 = '0, raa8 = '0, rab8 = '0;
    logic [7:0] wd8 = '0;
    logic [7:0] da_p, db_p, oh_p, da_z, db_z, oh_z;
    logic       va_p, vb_p, va_z, vb_z;

    // 16x32 stimulus
    logic        rst16 = 1'b1, we16 = 1'b0, rea16 = 1'b0, reb16 = 1'b0;
    logic [4:0]  wa16 = '0, raa16 = '0, rab16 = '0;
    logic [15:0] wd16 = '0;
    logic [15:0] da16, db16;
    logic [31:0] oh16;
    logic        va16, vb16;

    register_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut_plain (
        .clk(clk), .reset(rst8), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8),
        .rd_en_a(rea8), .rd_addr_a(raa8), .rd_en_b(reb8), .rd_addr_b(rab8),
        .rd_data_a(da_p), .rd_data_b(db_p), .rd_valid_a(va_p), .rd_valid_b(vb_p),
        .wr_onehot(oh_p)
    );

    register_bank #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut_zero (
        .clk(clk), .reset(rst8), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8),
        .rd_en_a(rea8), .rd_addr_a(raa8), .rd_en_b(reb8), .rd_addr_b(rab8),
        .rd_data_a(da_z), .rd_data_b(db_z), .rd_valid_a(va_z), .rd_valid_b(vb_z),
        .wr_onehot(oh_z)
    );

    register_bank #(.WIDTH(16), .DEPTH(32), .ZERO_REG(0)) dut_wide (
        .clk(clk), .reset(rst16), .wr_en(we16), .wr_addr(wa16), .wr_data(wd16),
        .rd_en_a(rea16), .rd_addr_a(raa16), .rd_en_b(reb16), .rd_addr_b(rab16),
        .rd_data_a(da16), .rd_data_b(db16), .rd_valid_a(va16), .rd_valid_b(vb16),
        .wr_onehot(oh16)
    );

    // reference model state, 8x8 pair
    logic [7:0] mp [8];
    logic [7:0] mz [8];
    logic [7:0] e_da_p, e_db_p, e_da_z, e_db_z, e_oh_p, e_oh_z;
    logic       e_va8, e_vb8;

    // reference model state, 16x32
    logic [15:0] m16 [32];
    logic [15:0] e_da16, e_db16;
    logic [31:0] e_oh16;
    logic        e_va16, e_vb16;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, actual, expected, $time);
        end
    endtask

    // one clock of the 8x8 pair: drive, clock, update model (write first, then read), compare
    task automatic applyStimulus8(input logic rst, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                  input logic rea, input logic [2:0] raa, input logic reb, input logic [2:0] rab);
        rst8 = rst; we8 = we; wa8 = wa; wd8 = wd;
        rea8 = rea; raa8 = raa; reb8 = reb; rab8 = rab;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mp[i] = '0;
                mz[i] = '0;
            end
            e_da_p = '0; e_db_p = '0; e_da_z = '0; e_db_z = '0;
            e_oh_p = '0; e_oh_z = '0; e_va8 = 1'b0; e_vb8 = 1'b0;
        end else begin
            e_oh_p = '0;
            e_oh_z = '0;
            if (we) begin
                mp[wa] = wd;
                e_oh_p[wa] = 1'b1;
                if (wa != 3'd0) begin
                    mz[wa] = wd;
                    e_oh_z[wa] = 1'b1;
                end
            end
            e_va8 = rea;
            e_vb8 = reb;
            if (rea) begin
                e_da_p = mp[raa];
                e_da_z = mz[raa];
            end
            if (reb) begin
                e_db_p = mp[rab];
                e_db_z = mz[rab];
            end
        end
        checkOutput("p_rd_data_a", da_p, e_da_p);
        checkOutput("p_rd_data_b", db_p, e_db_p);
        checkOutput("p_rd_valid_a", va_p, e_va8);
        checkOutput("p_rd_valid_b", vb_p, e_vb8);
        checkOutput("p_wr_onehot", oh_p, e_oh_p);
        checkOutput("z_rd_data_a", da_z, e_da_z);
        checkOutput("z_rd_data_b", db_z, e_db_z);
        checkOutput("z_rd_valid_a", va_z, e_va8);
        checkOutput("z_rd_valid_b", vb_z, e_vb8);
        checkOutput("z_wr_onehot", oh_z, e_oh_z);
    endtask

    // one clock of the 16x32 instance
    task automatic applyStimulus16(input logic rst, input logic we, input logic [4:0] wa, input logic [15:0] wd,
                                   input logic rea, input logic [4:0] raa, input logic reb, input logic [4:0] rab);
        rst16 = rst; we16 = we; wa16 = wa; wd16 = wd;
        rea16 = rea; raa16 = raa; reb16 = reb; rab16 = rab;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m16[i] = '0;
            e_da16 = '0; e_db16 = '0; e_oh16 = '0; e_va16 = 1'b0; e_vb16 = 1'b0;
        end else begin
            e_oh16 = '0;
            if (we) begin
                m16[wa] = wd;
                e_oh16[wa] = 1'b1;
            end
            e_va16 = rea;
            e_vb16 = reb;
            if (rea) e_da16 = m16[raa];
            if (reb) e_db16 = m16[rab];
        end
        checkOutput("w_rd_data_a", da16, e_da16);
        checkOutput("w_rd_data_b", db16, e_db16);
        checkOutput("w_rd_valid_a", va16, e_va16);
        checkOutput("w_rd_valid_b", vb16, e_vb16);
        checkOutput("w_wr_onehot", oh16, e_oh16);
    endtask

    // safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    logic        r_rst, r_we, r_rea, r_reb;
    logic [2:0]  r_wa8, r_raa8, r_rab8;
    logic [4:0]  r_wa, r_raa, r_rab;
    logic [7:0]  r_wd8;
    logic [15:0] r_wd;

    initial begin
        $display("[TB] start");

        // reset state
        applyStimulus8(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus8(1, 1, 3, 8'h5A, 1, 3, 1, 3);
        checkOutput("reset_valid_a", va_p, 1'b0);
        checkOutput("reset_onehot", oh_p, 8'h00);

        // every entry reads zero after reset
        for (int i = 0; i < 8; i++) begin
            applyStimulus8(0, 0, 0, 0, 1, 3'(i), 0, 0);
            checkOutput("req030_data", da_p, 8'h00);
            checkOutput("req030_valid", va_p, 1'b1);
        end
        applyStimulus8(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_valid_a", va_p, 1'b0);

        // write 0xA5 to 3, then dual read
        applyStimulus8(0, 1, 3, 8'hA5, 0, 0, 0, 0);
        checkOutput("req031_onehot", oh_p, 8'b0000_1000);
        applyStimulus8(0, 0, 0, 0, 1, 3, 1, 3);
        checkOutput("req031_a", da_p, 8'hA5);
        checkOutput("req031_b", db_p, 8'hA5);
        checkOutput("req031_onehot_clear", oh_p, 8'h00);

        // held data when read not requested
        applyStimulus8(0, 0, 0, 0, 0, 5, 0, 6);
        checkOutput("hold_a", da_p, 8'hA5);

        // same-edge write/read bypass
        applyStimulus8(0, 1, 5, 8'h11, 0, 0, 0, 0);
        applyStimulus8(0, 1, 5, 8'h3C, 1, 5, 1, 3);
        checkOutput("req032_bypass", da_p, 8'h3C);
        checkOutput("req032_other", db_p, 8'hA5);

        // entry 0 hardwired zero on the second instance
        applyStimulus8(0, 1, 0, 8'hFF, 1, 0, 0, 0);
        checkOutput("req033_onehot_z", oh_z, 8'h00);
        checkOutput("req033_bypass_z", da_z, 8'h00);
        applyStimulus8(0, 0, 0, 0, 1, 0, 1, 0);
        checkOutput("req033_read_z", da_z, 8'h00);
        checkOutput("req033_read_p", da_p, 8'hFF);

        // consecutive writes to one entry, last wins
        applyStimulus8(0, 1, 4, 8'h01, 0, 0, 0, 0);
        applyStimulus8(0, 1, 4, 8'h02, 0, 0, 0, 0);
        applyStimulus8(0, 1, 4, 8'h03, 0, 0, 0, 0);
        applyStimulus8(0, 0, 0, 0, 1, 4, 0, 0);
        checkOutput("last_write_wins", da_p, 8'h03);

        // reset mid-stream discards read and write
        applyStimulus8(0, 1, 2, 8'h77, 1, 4, 0, 0);
        applyStimulus8(1, 1, 6, 8'h99, 1, 2, 1, 2);
        checkOutput("req034_valid", va_p, 1'b0);
        checkOutput("req034_data", da_p, 8'h00);
        applyStimulus8(0, 0, 0, 0, 1, 2, 1, 6);
        checkOutput("req034_read", da_p, 8'h00);
        checkOutput("req034_discard_wr", db_p, 8'h00);
        checkOutput("req034_valid_after", va_p, 1'b1);

        // randomized stream on the 8x8 pair
        for (int n = 0; n < 2000; n++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_rea = ($urandom_range(0, 3) != 0);
            r_reb = ($urandom_range(0, 3) != 0);
            r_wa8 = 3'($urandom_range(0, 7));
            r_raa8 = ($urandom_range(0, 2) == 0) ? r_wa8 : 3'($urandom_range(0, 7));
            r_rab8 = ($urandom_range(0, 2) == 0) ? r_raa8 : 3'($urandom_range(0, 7));
            r_wd8 = 8'($urandom);
            applyStimulus8(r_rst, r_we, r_wa8, r_wd8, r_rea, r_raa8, r_reb, r_rab8);
        end

        // long randomized stream on the 16x32 instance
        applyStimulus16(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10000; n++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_we  = ($urandom_range(0, 7) != 0);
            r_rea = ($urandom_range(0, 3) != 0);
            r_reb = ($urandom_range(0, 3) != 0);
            r_wa  = 5'($urandom_range(0, 31));
            r_raa = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_rab = ($urandom_range(0, 3) == 0) ? r_raa : 5'($urandom_range(0, 31));
            r_wd  = 16'($urandom);
            applyStimulus16(r_rst, r_we, r_wa, r_wd, r_rea, r_raa, r_reb, r_rab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 8: number of entries, power of two, legal range 2..256; AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 0: when 1, entry 0 always reads as zero and ignores writes.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  AW  write entry index.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_en_a / rd_en_b  input  1 each  read request, port A / port B.
REQ-010 rd_addr_a / rd_addr_b  input  AW each  read entry index, port A / port B.
REQ-011 rd_data_a / rd_data_b  output  WIDTH each  registered read data.
REQ-012 rd_valid_a / rd_valid_b  output  1 each  high for exactly the cycle the matching rd_data holds a new result.
REQ-013 wr_onehot  output  DEPTH  registered one-hot copy of the last write; bit i means entry i (LSB = entry 0).

Function
REQ-014 Write: wr_en=1 at an edge stores wr_data into entry wr_addr; no other entry changes.
REQ-015 Read latency is one cycle: rd_en_x=1 at edge N loads rd_data_x at edge N, visible in cycle N+1 with rd_valid_x=1.
REQ-016 rd_en_x=0 at an edge sets rd_valid_x=0 and holds rd_data_x unchanged.
REQ-017 Write-first bypass: read and write of the same address at the same edge return wr_data, not the old contents.
REQ-018 Ports A and B are independent; both reading the same address in one cycle return identical data.
REQ-019 ZERO_REG=1: writes to entry 0 are dropped, reads of entry 0 return 0 (bypass included); wr_onehot stays all-zero for such a write.
REQ-020 wr_onehot: at each edge, wr_onehot = (1 << wr_addr) if an effective write occurs, otherwise all zeros; pulses for one cycle per write.
REQ-021 Back-to-back writes and reads on consecutive cycles run at full rate without stalls or bubbles.
REQ-022 Addresses are always in range (DEPTH is a power of two); no out-of-range handling exists.
REQ-023 Consecutive writes to one entry: the final write wins; a read in the cycle after returns the latest value.
REQ-024 The block contains no combinational path from any input to any output.

Reset
REQ-025 reset=1 at an edge clears every entry to 0.
REQ-026 reset=1 at an edge forces rd_data_a, rd_data_b to 0, rd_valid_a, rd_valid_b to 0, wr_onehot to 0.
REQ-027 reset takes priority: wr_en and rd_en_x sampled in the same edge as reset are discarded and produce no valid or write.
REQ-028 First operation is accepted at the first edge with reset=0.
REQ-029 Reset asserted mid-stream discards any read requested at that edge; a read requested the cycle before reset still shows valid in the reset cycle only if completed before the resetting edge (i.e. valid drops at the reset edge).

Verification
REQ-030 Reset then read all 8 entries on port A (WIDTH=8, DEPTH=8) -> every rd_data_a = 0x00, rd_valid_a high one cycle after each request.
REQ-031 Write 0xA5 to entry 3, next cycle read entry 3 on A and B -> both return 0xA5 one cycle later; wr_onehot = 0b00001000 for one cycle after the write.
REQ-032 Same edge: write 0x3C to entry 5, rd_en_a=1 rd_addr_a=5 (old value 0x11) -> rd_data_a = 0x3C next cycle.
REQ-033 ZERO_REG=1: write 0xFF to entry 0, then read entry 0 -> rd_data = 0x00, wr_onehot stays 0.
REQ-034 Write 0x77 to entry 2, assert reset one cycle with rd_en_a=1 rd_addr_a=2, then read entry 2 -> rd_valid_a=0 after reset edge, later read returns 0x00.
REQ-035 Random stream, 10k cycles, WIDTH=16 DEPTH=32, both ports plus writes every cycle -> outputs match a reference-model scoreboard including bypass cases.
